// File: rtl/spi_transaction_sequencer.sv
// spi_transaction_sequencer
//   Buffers SPI commands in a command FIFO and feeds them, one at a time, to a
//   quick_spi master. Each command is popped into hold registers that stay
//   stable for the whole transaction, a one-cycle start pulse is issued, and
//   the sequencer waits for the master's end pulse (or a timeout). READ results
//   are pushed into a response FIFO tagged with the slave index.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_operation/slave/data        command fields (0 = READ, 1 = WRITE)
//   rsp_valid/rsp_ready             response handshake (FIFO head)
//   rsp_data/rsp_slave              read word and its slave index
//   busy                            FSM active or commands pending
//   timeout_error                   sticky timeout flag
//   spi_enable                      master enable, low only in reset
//   spi_start_transaction           one-cycle start pulse
//   spi_operation/slave/outgoing_data  held command fields
//   spi_end_of_transaction          master done pulse
//   spi_incoming_data               master read result
module spi_transaction_sequencer #(
   parameter int INCOMING_DATA_WIDTH = 8,
   parameter int OUTGOING_DATA_WIDTH = 16,
   parameter int NUMBER_OF_SLAVES    = 2,
   parameter int CMD_FIFO_DEPTH      = 4,
   parameter int RSP_FIFO_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES      = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic                           cmd_operation,
   input  logic [NUMBER_OF_SLAVES-1:0]    cmd_slave,
   input  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [INCOMING_DATA_WIDTH-1:0] rsp_data,
   output logic [NUMBER_OF_SLAVES-1:0]    rsp_slave,
   output logic                           busy,
   output logic                           timeout_error,
   output logic                           spi_enable,
   output logic                           spi_start_transaction,
   output logic                           spi_operation,
   output logic [NUMBER_OF_SLAVES-1:0]    spi_slave,
   output logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data,
   input  logic                           spi_end_of_transaction,
   input  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data
);
   localparam int CAW = $clog2(CMD_FIFO_DEPTH);
   localparam int RAW = $clog2(RSP_FIFO_DEPTH);
   localparam int CW  = 1 + NUMBER_OF_SLAVES + OUTGOING_DATA_WIDTH;
   localparam int RW  = NUMBER_OF_SLAVES + INCOMING_DATA_WIDTH;
   localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_EOT, S_STORE, S_GAP} state_t;
   state_t r_state, w_state_nxt;

   logic w_cmd_pop, w_rsp_push, w_start, w_capture, w_timeout, w_cnt_inc;

   // ---------------- command FIFO ----------------
   logic [CW-1:0]  r_cmd_mem [CMD_FIFO_DEPTH];
   logic [CAW-1:0] r_cmd_wptr, r_cmd_rptr;
   logic [CAW:0]   r_cmd_level;
   logic           w_cmd_full, w_cmd_empty, w_cmd_push;
   logic [CW-1:0]  w_cmd_head;

   assign w_cmd_full  = (r_cmd_level == (CAW+1)'(CMD_FIFO_DEPTH));
   assign w_cmd_empty = (r_cmd_level == '0);
   // Ready depends only on registered level, so a same-cycle pop never frees a slot early.
   assign cmd_ready   = !w_cmd_full && !reset;
   assign w_cmd_push  = cmd_valid && cmd_ready;
   assign w_cmd_head  = r_cmd_mem[r_cmd_rptr];

   always_ff @(posedge clk)
      if (w_cmd_push) r_cmd_mem[r_cmd_wptr] <= {cmd_operation, cmd_slave, cmd_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmd_wptr  <= '0;
         r_cmd_rptr  <= '0;
         r_cmd_level <= '0;
      end else begin
         if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + 1'b1;
         if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + 1'b1;
         case ({w_cmd_push, w_cmd_pop})
            2'b10:   r_cmd_level <= r_cmd_level + 1'b1;
            2'b01:   r_cmd_level <= r_cmd_level - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- response FIFO ----------------
   logic [RW-1:0]  r_rsp_mem [RSP_FIFO_DEPTH];
   logic [RAW-1:0] r_rsp_wptr, r_rsp_rptr;
   logic [RAW:0]   r_rsp_level;
   logic           w_rsp_full, w_rsp_empty, w_rsp_pop;

   assign w_rsp_full  = (r_rsp_level == (RAW+1)'(RSP_FIFO_DEPTH));
   assign w_rsp_empty = (r_rsp_level == '0);
   assign rsp_valid   = !w_rsp_empty;
   assign w_rsp_pop   = rsp_valid && rsp_ready;
   assign {rsp_slave, rsp_data} = r_rsp_mem[r_rsp_rptr];

   // ---------------- hold / capture / timeout ----------------
   logic                           r_op;
   logic [NUMBER_OF_SLAVES-1:0]    r_slave;
   logic [OUTGOING_DATA_WIDTH-1:0] r_out;
   logic [INCOMING_DATA_WIDTH-1:0] r_cap;
   logic [TW-1:0]                  r_cnt;
   logic                           r_timeout, r_spi_enable;

   always_ff @(posedge clk)
      if (w_rsp_push) r_rsp_mem[r_rsp_wptr] <= {r_slave, r_cap};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_wptr  <= '0;
         r_rsp_rptr  <= '0;
         r_rsp_level <= '0;
      end else begin
         if (w_rsp_push) r_rsp_wptr <= r_rsp_wptr + 1'b1;
         if (w_rsp_pop)  r_rsp_rptr <= r_rsp_rptr + 1'b1;
         case ({w_rsp_push, w_rsp_pop})
            2'b10:   r_rsp_level <= r_rsp_level + 1'b1;
            2'b01:   r_rsp_level <= r_rsp_level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op         <= 1'b0;
         r_slave      <= '0;
         r_out        <= '0;
         r_cap        <= '0;
         r_cnt        <= '0;
         r_timeout    <= 1'b0;
         r_spi_enable <= 1'b0;
      end else begin
         r_spi_enable <= 1'b1;
         if (w_cmd_pop) begin
            {r_op, r_slave, r_out} <= w_cmd_head;
            r_cnt                  <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_capture) r_cap     <= spi_incoming_data;
         if (w_timeout) r_timeout <= 1'b1;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_pop   = 1'b0;
      w_start     = 1'b0;
      w_rsp_push  = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         S_IDLE: if (!w_cmd_empty) begin
            w_cmd_pop   = 1'b1;
            w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            w_start     = 1'b1;
            w_state_nxt = S_WAIT_EOT;
         end
         S_WAIT_EOT: begin
            w_cnt_inc = 1'b1;
            if (spi_end_of_transaction) begin
               if (!r_op) begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_STORE;
               end else begin
                  w_state_nxt = S_GAP;
               end
            end else if (r_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               // command is dropped; no response is produced for it
               w_timeout   = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         // stall rather than drop when the consumer is slow
         S_STORE: if (!w_rsp_full) begin
            w_rsp_push  = 1'b1;
            w_state_nxt = S_GAP;
         end
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign spi_start_transaction = w_start;
   assign spi_operation         = r_op;
   assign spi_slave             = r_slave;
   assign spi_outgoing_data     = r_out;
   assign spi_enable            = r_spi_enable;
   assign timeout_error         = r_timeout;
   assign busy                  = (r_state != S_IDLE) || !w_cmd_empty;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Bench for spi_transaction_sequencer: a queue-based reference (accepted
// commands, expected read responses) with a behavioural SPI master and a
// response monitor. A second instance with a short timeout covers the
// timeout behaviour.
module tb_spi_transaction_sequencer;
   localparam int IW = 8, OW = 16, NS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- main instance ----------------
   logic reset, cmd_valid, cmd_ready, cmd_operation;
   logic [NS-1:0] cmd_slave, rsp_slave, spi_slave;
   logic [OW-1:0] cmd_data, spi_outgoing_data;
   logic rsp_valid, rsp_ready, busy, timeout_error, spi_enable, spi_start_transaction, spi_operation;
   logic [IW-1:0] rsp_data, spi_incoming_data;
   logic spi_end_of_transaction;

   spi_transaction_sequencer dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_operation(cmd_operation), .cmd_slave(cmd_slave), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_slave(rsp_slave),
      .busy(busy), .timeout_error(timeout_error), .spi_enable(spi_enable),
      .spi_start_transaction(spi_start_transaction), .spi_operation(spi_operation),
      .spi_slave(spi_slave), .spi_outgoing_data(spi_outgoing_data),
      .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data));

   // ---------------- short-timeout instance ----------------
   logic t_reset, t_cmd_valid, t_cmd_ready, t_cmd_operation;
   logic [NS-1:0] t_cmd_slave, t_rsp_slave, t_spi_slave;
   logic [OW-1:0] t_cmd_data, t_spi_out;
   logic t_rsp_valid, t_rsp_ready, t_busy, t_timeout_error, t_spi_enable, t_start, t_spi_operation;
   logic [IW-1:0] t_rsp_data, t_in;
   logic t_eot;

   spi_transaction_sequencer #(.TIMEOUT_CYCLES(16)) dut_to (
      .clk(clk), .reset(t_reset), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
      .cmd_operation(t_cmd_operation), .cmd_slave(t_cmd_slave), .cmd_data(t_cmd_data),
      .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_slave(t_rsp_slave),
      .busy(t_busy), .timeout_error(t_timeout_error), .spi_enable(t_spi_enable),
      .spi_start_transaction(t_start), .spi_operation(t_spi_operation),
      .spi_slave(t_spi_slave), .spi_outgoing_data(t_spi_out),
      .spi_end_of_transaction(t_eot), .spi_incoming_data(t_in));

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          op;
      logic [NS-1:0] sl;
      logic [OW-1:0] d;
      logic [IW-1:0] rd;
      logic [7:0]    lat;
   } cmd_t;
   typedef struct packed {
      logic [NS-1:0] sl;
      logic [IW-1:0] d;
   } rsp_t;

   cmd_t cmd_q[$];   // accepted, not yet started
   rsp_t exp_q[$];   // expected responses in order

   bit   fix_rdy = 0, rnd_rdy = 0, chk_gap = 0;
   bit   m_busy = 0, hold_bad = 0, last_end_rd = 0;
   int   m_st = 0, last_end_edge = -100, n_start = 0;
   cmd_t m_cur;

   // Observation convention: a value seen at a negedge is the one the DUT
   // samples at posedge number cyc+1.

   // SPI master model
   initial begin
      spi_end_of_transaction = 1'b0;
      spi_incoming_data      = '0;
      forever begin
         @(negedge clk); #1;
         spi_end_of_transaction = 1'b0;
         if (reset) begin
            m_busy = 0;
            continue;
         end
         if (m_busy && (spi_operation !== m_cur.op || spi_slave !== m_cur.sl ||
                        spi_outgoing_data !== m_cur.d))
            hold_bad = 1;
         if (spi_start_transaction) begin
            n_start++;
            chk("overlapping start", {31'd0, m_busy}, 0);
            if (chk_gap) chk("start gap", cyc + 1 - last_end_edge, last_end_rd ? 4 : 3);
            if (cmd_q.size() == 0) begin
               chk("start without command", 1, 0);
            end else begin
               m_cur = cmd_q.pop_front();
               chk("start op",    {31'd0, spi_operation}, {31'd0, m_cur.op});
               chk("start slave", {30'd0, spi_slave},     {30'd0, m_cur.sl});
               chk("start data",  {16'd0, spi_outgoing_data}, {16'd0, m_cur.d});
               m_busy   = 1;
               hold_bad = 0;
               m_st     = cyc + 1;
            end
         end else if (m_busy && (cyc + 1 == m_st + int'(m_cur.lat))) begin
            spi_end_of_transaction = 1'b1;
            spi_incoming_data      = m_cur.rd;
            chk("fields held", {31'd0, hold_bad}, 0);
            last_end_edge = cyc + 1;
            last_end_rd   = !m_cur.op;
            m_busy        = 0;
         end
      end
   end

   // response ready driver
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk); #2;
         rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
      end
   end

   // response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk); #3;
         if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected response", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_data",  {24'd0, rsp_data},  {24'd0, e.d});
               chk("rsp_slave", {30'd0, rsp_slave}, {30'd0, e.sl});
            end
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic send(input logic op, input logic [NS-1:0] sl, input logic [OW-1:0] d,
                       input logic [IW-1:0] rd, input int lat, output int acc);
      int   n = 0;
      cmd_t c;
      cmd_valid = 1'b1; cmd_operation = op; cmd_slave = sl; cmd_data = d;
      while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         chk("command accept wait", 0, 1);
         cmd_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      c.op = op; c.sl = sl; c.d = d; c.rd = rd; c.lat = 8'(lat);
      cmd_q.push_back(c);
      if (!op) exp_q.push_back({sl, rd});
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(output int st);
      int n = 0;
      @(negedge clk);
      while (!spi_start_transaction && n < 200) begin @(negedge clk); n++; end
      if (!spi_start_transaction) begin chk("start wait", 0, 1); st = -1; end
      else st = cyc + 1;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while ((busy || m_busy || exp_q.size() != 0) && n < lim) begin @(negedge clk); n++; end
      chk("idle wait", {31'd0, (busy || m_busy || exp_q.size() != 0)}, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int acc, st, base, n, to_cyc;
      reset = 1; cmd_valid = 0; cmd_operation = 0; cmd_slave = '0; cmd_data = '0;
      t_reset = 1; t_cmd_valid = 0; t_cmd_operation = 0; t_cmd_slave = '0; t_cmd_data = '0;
      t_rsp_ready = 1; t_eot = 0; t_in = '0;
      repeat (3) @(negedge clk);

      // reset values
      chk("reset cmd_ready",  {31'd0, cmd_ready}, 0);
      chk("reset spi_enable", {31'd0, spi_enable}, 0);
      chk("reset busy",       {31'd0, busy}, 0);
      chk("reset rsp_valid",  {31'd0, rsp_valid}, 0);
      chk("reset timeout",    {31'd0, timeout_error}, 0);
      chk("reset start",      {31'd0, spi_start_transaction}, 0);
      reset = 0; t_reset = 0;
      @(negedge clk);
      chk("post-reset spi_enable", {31'd0, spi_enable}, 1);
      chk("post-reset cmd_ready",  {31'd0, cmd_ready}, 1);

      // single READ
      send(1'b0, 2'd1, 16'hA55A, 8'h3C, 20, acc);
      wait_start(st);
      chk("read start latency", st - acc, 2);
      chk("read spi_slave", {30'd0, spi_slave}, 1);
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      chk("rsp_valid after end", cyc + 1 - last_end_edge, 2);
      fix_rdy = 1;
      wait_idle(100);

      // single WRITE
      fix_rdy = 0; base = n_start;
      send(1'b1, 2'd2, 16'h1234, 8'h00, 8, acc);
      wait_start(st);
      chk("write outgoing data", {16'd0, spi_outgoing_data}, 32'h1234);
      wait_idle(100);
      repeat (5) @(negedge clk);
      chk("write no response", {31'd0, rsp_valid}, 0);
      chk("write start count", n_start - base, 1);

      // fill command FIFO while the master is stalled
      fix_rdy = 1;
      send(1'b0, 2'd0, 16'h0001, 8'h11, 40, acc);
      wait_start(st);
      @(negedge clk);
      chk_gap = 1;
      for (int i = 1; i <= 4; i++)
         send(1'b0, 2'(i), 16'(i), 8'(8'h20 + i), 3, acc);
      chk("cmd_ready after 4th", {31'd0, cmd_ready}, 0);
      cmd_valid = 1'b1; cmd_operation = 1'b0; cmd_data = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full FIFO rejects", {31'd0, cmd_ready}, 0);
      end
      cmd_valid = 1'b0;
      wait_idle(300);
      chk_gap = 0;

      // response back-pressure
      fix_rdy = 0; base = n_start;
      for (int i = 0; i < 6; i++)
         send(1'b0, 2'(i), 16'(16'h100 + i), 8'($urandom), 2, acc);
      repeat (40) @(negedge clk);
      chk("stalled start count", n_start - base, 5);
      chk("stalled busy", {31'd0, busy}, 1);
      chk("stalled rsp_valid", {31'd0, rsp_valid}, 1);
      fix_rdy = 1;
      @(negedge clk);
      fix_rdy = 0;
      repeat (30) @(negedge clk);
      chk("released start count", n_start - base, 6);
      fix_rdy = 1;
      wait_idle(200);

      // randomized traffic
      rnd_rdy = 1;
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 8'($urandom),
              $urandom_range(1, 12), acc);
      end
      rnd_rdy = 0; fix_rdy = 1;
      wait_idle(2000);

      // reset during WAIT_EOT with a response already buffered
      fix_rdy = 0;
      send(1'b0, 2'd3, 16'h7777, 8'h5E, 2, acc);
      repeat (15) @(negedge clk);
      chk("buffered rsp before reset", {31'd0, rsp_valid}, 1);
      send(1'b0, 2'd1, 16'h8888, 8'h99, 30, acc);
      wait_start(st);
      repeat (3) @(negedge clk);
      reset = 1;
      cmd_q.delete(); exp_q.delete();
      @(negedge clk);
      chk("mid reset start",     {31'd0, spi_start_transaction}, 0);
      chk("mid reset enable",    {31'd0, spi_enable}, 0);
      chk("mid reset rsp_valid", {31'd0, rsp_valid}, 0);
      chk("mid reset busy",      {31'd0, busy}, 0);
      chk("mid reset cmd_ready", {31'd0, cmd_ready}, 0);
      chk("mid reset spi_slave", {30'd0, spi_slave}, 0);
      chk("mid reset out data",  {16'd0, spi_outgoing_data}, 0);
      reset = 0;
      @(negedge clk);
      chk("after reset cmd_ready", {31'd0, cmd_ready}, 1);
      fix_rdy = 1;
      repeat (40) @(negedge clk);
      chk("no response after reset", {31'd0, rsp_valid}, 0);
      chk("idle after reset", {31'd0, busy}, 0);

      // timeout instance
      chk("t cmd_ready", {31'd0, t_cmd_ready}, 1);
      t_cmd_valid = 1; t_cmd_operation = 0; t_cmd_slave = 2'd2; t_cmd_data = 16'h0F0F;
      @(negedge clk);
      t_cmd_valid = 0;
      n = 0;
      while (!t_start && n < 20) begin @(negedge clk); n++; end
      st = cyc + 1;
      n = 0;
      while (!t_timeout_error && n < 100) begin @(negedge clk); n++; end
      to_cyc = cyc;
      chk("timeout latency", to_cyc - st, 16);
      repeat (5) @(negedge clk);
      chk("timeout no response", {31'd0, t_rsp_valid}, 0);
      chk("timeout idle", {31'd0, t_busy}, 0);
      // end pulse while idle must be ignored
      t_eot = 1; t_in = 8'hAA;
      @(negedge clk);
      t_eot = 0;
      repeat (4) @(negedge clk);
      chk("stray end ignored", {31'd0, t_rsp_valid}, 0);
      // a READ after the timeout completes normally
      t_cmd_valid = 1; t_cmd_operation = 0; t_cmd_slave = 2'd1; t_cmd_data = 16'h5A5A;
      t_rsp_ready = 0;
      @(negedge clk);
      t_cmd_valid = 0;
      n = 0;
      while (!t_start && n < 20) begin @(negedge clk); n++; end
      chk("post-timeout start", {31'd0, t_start}, 1);
      chk("post-timeout data", {16'd0, t_spi_out}, 32'h5A5A);
      repeat (3) @(negedge clk);
      t_eot = 1; t_in = 8'h77;
      @(negedge clk);
      t_eot = 0;
      repeat (4) @(negedge clk);
      chk("post-timeout rsp_valid", {31'd0, t_rsp_valid}, 1);
      chk("post-timeout rsp_data",  {24'd0, t_rsp_data}, 32'h77);
      chk("post-timeout rsp_slave", {30'd0, t_rsp_slave}, 1);
      chk("timeout sticky", {31'd0, t_timeout_error}, 1);
      t_reset = 1;
      @(negedge clk);
      t_reset = 0;
      chk("timeout cleared by reset", {31'd0, t_timeout_error}, 0);
      chk("t rsp flushed by reset", {31'd0, t_rsp_valid}, 0);

      chk("commands left unissued", cmd_q.size(), 0);
      chk("responses left unseen", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global guard
   initial begin
      #400000;
      $display("FAIL global timeout: got running want finished");
      $fatal(1, "simulation time limit");
   end
endmodule
